// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder controller: state encodings and default width.
package serial_add_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int SA_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_DONE  = ST_DONE
  } sa_state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; the per-bit datapath reused every cycle by serial_adder_ctrl.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder reused LSB-first over WIDTH bits with start/ready/done handshake.
// Optional signed-overflow output ovf is built when SERIAL_ADD_OVF_EN is defined.
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sa_state_t        state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q;
  logic             carry_q;
  logic             load, step, last;
  logic             fa_sum, fa_carry;
  logic [WIDTH:0]   sum_ext;

  full_adder u_fa (
    .a     (a_sr_q[0]),
    .b     (b_sr_q[0]),
    .c     (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // New sum bit enters at the MSB; after WIDTH steps bit 0 holds the first (LSB) result.
  assign sum_ext = {fa_sum, sum};
  assign last    = (cnt_q == CNT_LAST);
  assign ready   = (state_q == S_IDLE);
  assign busy    = (state_q == S_SHIFT);

  always_comb begin
    state_nxt = state_q;
    load      = 1'b0;
    step      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        step = 1'b1;
        if (last) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      done    <= 1'b0;
      cnt_q   <= '0;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      carry_q <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      state_q <= state_nxt;
      done    <= step & last;
      if (load) begin
        a_sr_q  <= a;
        b_sr_q  <= b;
        carry_q <= cin;
        cnt_q   <= '0;
      end else if (step) begin
        a_sr_q  <= a_sr_q >> 1;
        b_sr_q  <= b_sr_q >> 1;
        carry_q <= fa_carry;
        sum     <= sum_ext[WIDTH:1];
        cnt_q   <= cnt_q + 1'b1;
        if (last) begin
          cout <= fa_carry;
`ifdef SERIAL_ADD_OVF_EN
          // Carry into the MSB differing from carry out of it means signed overflow.
          ovf  <= carry_q ^ fa_carry;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8): stimulus pushes expectations, monitor pops on done.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0;
  logic         ready, busy, cout, done;
  logic [W-1:0] sum;
  logic         ovf_w;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  exp_t sb[$];
  logic prev_done = 1'b0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .ready (ready),
    .busy  (busy),
    .sum   (sum),
    .cout  (cout),
`ifdef SERIAL_ADD_OVF_EN
    .ovf   (ovf_w),
`endif
    .done  (done)
  );

`ifndef SERIAL_ADD_OVF_EN
  assign ovf_w = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (done && prev_done) check("done_width", 32'd2, 32'd1);
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sum", 32'(sum), 32'(e.s));
          check("cout", 32'(cout), 32'(e.c));
`ifdef SERIAL_ADD_OVF_EN
          check("ovf", 32'(ovf_w), 32'(e.o));
`endif
        end
      end
    end
    prev_done <= done;
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("ready_timeout", 32'(ready), 32'd1);
  endtask

  // Issue one add at a negedge, push expectation, then measure start-to-done latency in edges.
  task automatic do_add(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                        input logic [W-1:0] es, input logic ec, input logic eo);
    int n;
    wait_ready();
    a = va; b = vb; cin = vc; start = 1'b1;
    sb.push_back('{s: es, c: ec, o: eo});
    @(posedge clk);
    n = 1;
    @(negedge clk);
    start = 1'b0;
    while (!done && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("latency", 32'(n), 32'(W + 1));
  endtask

  int t0, tprev;
  logic [W-1:0] ta [4] = '{8'hC3, 8'h64, 8'hE0, 8'h00};
  logic [W-1:0] tb_ [4] = '{8'h5E, 8'h64, 8'hF0, 8'h00};
  logic         tc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [W-1:0] ts [4] = '{8'h21, 8'hC8, 8'hD1, 8'h01};
  logic         tco[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic         tov[4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);

    do_add(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    do_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    do_add(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);

    // Starts during SHIFT and DONE must be ignored.
    wait_ready();
    a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
    sb.push_back('{s: 8'h33, c: 1'b0, o: 1'b0});
    @(negedge clk);
    start = 1'b0;
    check("busy_in_shift", 32'(busy), 32'd1);
    a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    check("done_seen", 32'(done), 32'd1);
    check("ready_in_done", 32'(ready), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("hold_sum", 32'(sum), 32'h33);
    check("idle_ready", 32'(ready), 32'd1);

    // Reset mid-SHIFT at cnt=4: no done, reset values, then a clean add.
    a = 8'h0F; b = 8'hF0; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ready", 32'(ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_cout", 32'(cout), 32'd0);
    repeat (12) @(negedge clk);
    do_add(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

    // start held high: one acceptance every W+2 cycles.
    start = 1'b1;
    tprev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_ready();
      a = ta[i]; b = tb_[i]; cin = tc[i];
      sb.push_back('{s: ts[i], c: tco[i], o: tov[i]});
      t0 = cyc;
      if (i > 0) check("throughput", 32'(t0 - tprev), 32'(W + 2));
      tprev = t0;
      @(negedge clk);
    end
    start = 1'b0;

    do_add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    do_add(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    do_add(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded limit");
    $fatal(1, "timeout");
  end

endmodule
